// File: rtl/fall_feature_extract.sv
// Per-window mean and std-dev of Q8.8 accel magnitude; start pulses 19 cycles after the final window sample.
// Backpressure: none; a sample is taken on every sample_valid cycle, even while post-processing.
module fall_feature_extract #(
  parameter int WIN_LEN  = 32,
  parameter int LOG2_WIN = 5
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               sample_valid,
  input  logic signed [15:0] sample_mag,
  output logic        [31:0] feature_mean,
  output logic        [31:0] feature_std,
  output logic               start,
  output logic               busy
);

  localparam int SW = 16 + LOG2_WIN;
  localparam int QW = 32 + LOG2_WIN;

  typedef enum logic [2:0] {ACCUM, MEAN, VAR, SQRT, OUT} state_t;
  state_t state, state_next;

  logic signed [SW-1:0]       sum_acc, sum_next;
  logic        [QW-1:0]       sumsq_acc, sumsq_next;
  logic        [LOG2_WIN-1:0] cnt;
  logic signed [31:0]         mag_ext, mag_sq;
  logic                       window_done;

  logic signed [15:0] mean_snap;
  logic        [31:0] sumsq_snap;
  logic        [31:0] mean_sq;
  logic signed [31:0] mean_ext, mean_prod;
  logic        [32:0] var_diff;

  logic [19:0] rem, rem_next;
  logic [15:0] root;
  logic [31:0] rad;
  logic [3:0]  sqrt_cnt;
  logic [21:0] rem_sh, trial;
  logic        ge;

  assign mag_ext     = 32'(sample_mag);
  assign mag_sq      = mag_ext * mag_ext;
  assign sum_next    = sum_acc + SW'(sample_mag);
  assign sumsq_next  = sumsq_acc + {{LOG2_WIN{1'b0}}, mag_sq};
  assign window_done = sample_valid && (cnt == LOG2_WIN'(WIN_LEN - 1));

  assign mean_ext  = 32'(mean_snap);
  assign mean_prod = mean_ext * mean_ext;
  // Borrow out of bit 32 means mean^2 exceeded E[x^2] through truncation; clamp to zero.
  assign var_diff  = {1'b0, sumsq_snap} - {1'b0, mean_sq};

  // Restoring root: bring down two radicand bits, try subtracting 4*root+1.
  assign rem_sh   = {rem, rad[31:30]};
  assign trial    = {4'b0000, root, 2'b01};
  assign ge       = (rem_sh >= trial);
  assign rem_next = ge ? (rem_sh[19:0] - trial[19:0]) : rem_sh[19:0];

  assign busy = (state != ACCUM);

  always_comb begin
    state_next = state;
    case (state)
      ACCUM: if (window_done) state_next = MEAN;
      MEAN:  state_next = VAR;
      VAR:   state_next = SQRT;
      SQRT:  if (sqrt_cnt == 4'd15) state_next = OUT;
      OUT:   state_next = ACCUM;
      default: state_next = ACCUM;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ACCUM;
    end else begin
      state <= state_next;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sum_acc      <= '0;
      sumsq_acc    <= '0;
      cnt          <= '0;
      mean_snap    <= '0;
      sumsq_snap   <= '0;
      mean_sq      <= '0;
      rem          <= '0;
      root         <= '0;
      rad          <= '0;
      sqrt_cnt     <= '0;
      feature_mean <= '0;
      feature_std  <= '0;
      start        <= 1'b0;
    end else begin
      start <= 1'b0;

      if (sample_valid) begin
        if (window_done) begin
          // Snapshot only the bits that survive the divide by WIN_LEN.
          mean_snap  <= sum_next[SW-1 -: 16];
          sumsq_snap <= sumsq_next[QW-1 -: 32];
          sum_acc    <= '0;
          sumsq_acc  <= '0;
          cnt        <= '0;
        end else begin
          sum_acc    <= sum_next;
          sumsq_acc  <= sumsq_next;
          cnt        <= cnt + LOG2_WIN'(1);
        end
      end

      case (state)
        MEAN: mean_sq <= mean_prod;
        VAR: begin
          rad      <= var_diff[32] ? 32'd0 : var_diff[31:0];
          rem      <= '0;
          root     <= '0;
          sqrt_cnt <= '0;
        end
        SQRT: begin
          rem      <= rem_next;
          root     <= {root[14:0], ge};
          rad      <= {rad[29:0], 2'b00};
          sqrt_cnt <= sqrt_cnt + 4'd1;
        end
        OUT: begin
          feature_mean <= {{8{mean_snap[15]}}, mean_snap, 8'h00};
          feature_std  <= {8'h00, root, 8'h00};
          start        <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fall_feature_extract.sv
// Directed bench for fall_feature_extract: window results, start latency, reset aborts, back-to-back windows.
module tb_fall_feature_extract;

  logic        clk;
  logic        reset;
  logic        sample_valid;
  logic [15:0] sample_mag;
  logic [31:0] feature_mean;
  logic [31:0] feature_std;
  logic        start;
  logic        busy;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  int last_acc;
  int first_acc;
  int n0;

  int          start_cyc_q[$];
  logic [31:0] mean_q[$];
  logic [31:0] std_q[$];

  fall_feature_extract #(.WIN_LEN(32), .LOG2_WIN(5)) dut (
    .clk          (clk),
    .reset        (reset),
    .sample_valid (sample_valid),
    .sample_mag   (sample_mag),
    .feature_mean (feature_mean),
    .feature_std  (feature_std),
    .start        (start),
    .busy         (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Record each start pulse with the edge number that raised it and the features it presented.
  always @(negedge clk) begin
    if (start) begin
      start_cyc_q.push_back(cyc);
      mean_q.push_back(feature_mean);
      std_q.push_back(feature_std);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; drives one sample for the next rising edge and returns at the following negedge.
  task automatic send(input logic [15:0] v);
    sample_valid = 1'b1;
    sample_mag   = v;
    last_acc     = cyc + 1;
    @(negedge clk);
    sample_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    sample_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_window(input logic [15:0] a, input logic [15:0] b, input int max_gap);
    for (int i = 0; i < 32; i++) begin
      send((i % 2 == 0) ? a : b);
      if (max_gap > 0 && i < 31) idle($urandom_range(0, max_gap));
    end
  endtask

  // Reset pulse with a sample presented in the same cycle; reset must win.
  task automatic pulse_reset();
    reset        = 1'b1;
    sample_valid = 1'b1;
    sample_mag   = 16'h7FFF;
    @(negedge clk);
    reset        = 1'b0;
    sample_valid = 1'b0;
  endtask

  task automatic chk_window(input string tag, input logic [31:0] m, input logic [31:0] s);
    chk({tag, "_busy_after_last"}, {31'd0, busy}, 32'd1);
    idle(25);
    chk({tag, "_start_count"}, start_cyc_q.size(), n0 + 1);
    chk({tag, "_latency"}, start_cyc_q[$] - last_acc, 32'd19);
    chk({tag, "_pulse_mean"}, mean_q[$], m);
    chk({tag, "_pulse_std"}, std_q[$], s);
    chk({tag, "_mean_held"}, feature_mean, m);
    chk({tag, "_std_held"}, feature_std, s);
    chk({tag, "_busy_idle"}, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    reset        = 1'b1;
    sample_valid = 1'b0;
    sample_mag   = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;

    chk("rst_mean",  feature_mean, 32'h0);
    chk("rst_std",   feature_std,  32'h0);
    chk("rst_start", {31'd0, start}, 32'd0);
    chk("rst_busy",  {31'd0, busy},  32'd0);

    // Constant 1.0: mean 1.0, std 0.
    n0 = start_cyc_q.size();
    send_window(16'h0100, 16'h0100, 0);
    chk_window("ones", 32'h0001_0000, 32'h0000_0000);

    // +/-2.0 alternating: mean 0, var 4.0, std 2.0.
    n0 = start_cyc_q.size();
    send_window(16'h0200, 16'hFE00, 0);
    chk_window("alt2", 32'h0000_0000, 32'h0002_0000);

    // Constant -0.5, then a partial window that must not fire.
    n0 = start_cyc_q.size();
    send_window(16'hFF80, 16'hFF80, 0);
    chk_window("neg_half", 32'hFFFF_8000, 32'h0000_0000);
    n0 = start_cyc_q.size();
    for (int i = 0; i < 31; i++) send(16'h0100);
    idle(40);
    chk("partial_no_start", start_cyc_q.size(), n0);
    chk("partial_mean_held", feature_mean, 32'hFFFF_8000);
    chk("partial_std_held", feature_std, 32'h0);

    // Reset clears the 31-sample partial; gapped window must match the contiguous result.
    pulse_reset();
    chk("rst2_mean", feature_mean, 32'h0);
    n0 = start_cyc_q.size();
    send_window(16'h0100, 16'h0100, 3);
    chk_window("gaps", 32'h0001_0000, 32'h0000_0000);

    // Reset mid-window, then reset mid-SQRT: both abort silently.
    n0 = start_cyc_q.size();
    for (int i = 0; i < 20; i++) send(16'h0200);
    pulse_reset();
    chk("midwin_mean", feature_mean, 32'h0);
    chk("midwin_std",  feature_std,  32'h0);
    chk("midwin_busy", {31'd0, busy}, 32'd0);
    send_window(16'h0100, 16'h0100, 0);
    idle(6);
    chk("midsqrt_busy_before", {31'd0, busy}, 32'd1);
    pulse_reset();
    chk("midsqrt_busy_after", {31'd0, busy}, 32'd0);
    idle(30);
    chk("abort_no_start", start_cyc_q.size(), n0);
    chk("abort_mean", feature_mean, 32'h0);
    n0 = start_cyc_q.size();
    send_window(16'h0100, 16'h0100, 0);
    chk_window("after_abort", 32'h0001_0000, 32'h0000_0000);

    // Back-to-back windows: second window streams in while the first is post-processed.
    n0 = start_cyc_q.size();
    send_window(16'h0100, 16'h0100, 0);
    first_acc = last_acc;
    send_window(16'h0200, 16'hFE00, 0);
    idle(25);
    chk("b2b_start_count", start_cyc_q.size(), n0 + 2);
    if (start_cyc_q.size() >= n0 + 2) begin
      chk("b2b_lat1",  start_cyc_q[n0] - first_acc, 32'd19);
      chk("b2b_mean1", mean_q[n0], 32'h0001_0000);
      chk("b2b_std1",  std_q[n0],  32'h0000_0000);
      chk("b2b_gap",   start_cyc_q[n0+1] - start_cyc_q[n0], 32'd32);
      chk("b2b_mean2", mean_q[n0+1], 32'h0000_0000);
      chk("b2b_std2",  std_q[n0+1],  32'h0002_0000);
    end
    chk("b2b_lat2", start_cyc_q[$] - last_acc, 32'd19);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fall_feature_extract.md
FALL_FEATURE_EXTRACT -- requirements
Module: fall_feature_extract

Interface
REQ-001 SHALL have parameter WIN_LEN, default 32, samples per non-overlapping window (power of two, 32..256).
REQ-002 SHALL have parameter LOG2_WIN, default 5, log2(WIN_LEN).
REQ-003 SHALL have port clk, input, 1, single clock; all logic on rising edge.
REQ-004 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-005 SHALL have port sample_valid, input, 1, sample_mag valid this cycle.
REQ-006 SHALL have port sample_mag, input, 16, signed accel magnitude, Q8.8.
REQ-007 SHALL have port feature_mean, output, 32, signed window mean, Q16.16, to svm_inference.
REQ-008 SHALL have port feature_std, output, 32, signed (always >= 0) window std-dev, Q16.16, to svm_inference.
REQ-009 SHALL have port start, output, 1, one-cycle pulse: new feature pair valid.
REQ-010 SHALL have port busy, output, 1, high while post-processing a completed window (states MEAN..OUT).

Function
REQ-011 SHALL accept a sample on every cycle with sample_valid=1 regardless of state; no backpressure.
REQ-012 SHALL accumulate sum (signed, 16+LOG2_WIN bits) and sumsq (unsigned, 32+LOG2_WIN bits, x*x) plus a sample counter.
REQ-013 On the edge accepting sample WIN_LEN: snapshot sum/sumsq, clear accumulators and counter, enter MEAN; next window accumulates from the following sample.
REQ-014 States: ACCUM -> MEAN -> VAR -> SQRT (16 cycles) -> OUT -> ACCUM; ACCUM is the reset state.
REQ-015 MEAN: mean = snapshot sum >>> LOG2_WIN (arithmetic, floor toward -inf), 16-bit Q8.8; compute mean*mean (Q16.16).
REQ-016 VAR: var = (sumsq >> LOG2_WIN) - mean*mean, 32-bit unsigned Q16.16; negative result clamped to 0.
REQ-017 SQRT: restoring bit-serial integer square root of var, one result bit per cycle MSB first, 16 iterations, 16-bit Q8.8 floor root.
REQ-018 OUT: feature_mean <= sign-extended mean << 8; feature_std <= zero-extended root << 8; start <= 1 for exactly one cycle.
REQ-019 Latency: start SHALL be high in the cycle following the 19th rising edge after the edge accepting the final window sample.
REQ-020 feature_mean/feature_std SHALL hold stable between OUT updates (svm_inference reads them throughout its compute).
REQ-021 Because post-processing (19 cycles) < WIN_LEN, a window SHALL never complete while busy; no overrun logic required.
REQ-022 Partial windows SHALL never produce start; counter wrap occurs only at WIN_LEN.

Reset
REQ-023 reset=1 at a rising edge SHALL force state ACCUM, clear accumulators, counter, snapshots, SQRT registers; feature_mean=0, feature_std=0, start=0, busy=0.
REQ-024 reset SHALL override sample_valid in the same cycle; reset mid-window or mid-SQRT aborts with no start pulse.

Verification
REQ-025 32 samples 0x0100 (1.0), contiguous -> feature_mean=0x00010000, feature_std=0x00000000, start one cycle, 19 edges after last sample.
REQ-026 32 samples alternating +0x0200/-0x0200 -> feature_mean=0x00000000, var=0x00040000, feature_std=0x00020000.
REQ-027 32 samples 0xFF80 (-0.5) -> feature_mean=0xFFFF8000, feature_std=0; then 31 more samples and stop -> no further start, outputs unchanged.
REQ-028 32 samples 0x0100 with random idle gaps in sample_valid -> same outputs as REQ-025; start 19 edges after 32nd valid sample.
REQ-029 reset after 20 samples (and again during SQRT) -> outputs 0, no start; then 32 samples 0x0100 -> REQ-025 result.
REQ-030 64 contiguous samples (window 1 = 0x0100, window 2 = ±0x0200) -> two start pulses 32 cycles apart; second-window samples arriving while busy accepted; results per REQ-025 then REQ-026.
